// File: rtl/receive_fsm_pkg.sv
// Shared sizes and state encoding for the receive-side delay-and-sum block.
package receive_fsm_pkg;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 12;
  localparam int DELAY_W  = 6;
  localparam int COUNT_W  = 16;
  // Eight full-scale samples need three extra bits, so the sum never overflows.
  localparam int SUM_W    = SAMPLE_W + $clog2(NUM_CH);
  localparam int DEPTH    = 2 ** DELAY_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/receive_fsm_if.sv
// Control, ADC and A-line signals between the receive block and its surroundings.
interface receive_fsm_if;
  import receive_fsm_pkg::*;

  logic                         start_receive;
  logic                         abort;
  logic                         load_delays;
  logic [NUM_CH*DELAY_W-1:0]    rx_delays;
  logic [NUM_CH-1:0]            used_channels;
  logic [COUNT_W-1:0]           blank_cycles;
  logic [COUNT_W-1:0]           num_samples;
  logic [NUM_CH*SAMPLE_W-1:0]   adc_data;
  logic                         adc_valid;
  logic                         rx_enable;
  logic                         receive_in_progress;
  logic                         aline_valid;
  logic signed [SUM_W-1:0]      aline_data;
  logic                         aline_last;
  logic                         receive_complete;

  modport master (
    output start_receive, abort, load_delays, rx_delays, used_channels,
           blank_cycles, num_samples, adc_data, adc_valid,
    input  rx_enable, receive_in_progress, aline_valid, aline_data,
           aline_last, receive_complete
  );

  modport slave (
    input  start_receive, abort, load_delays, rx_delays, used_channels,
           blank_cycles, num_samples, adc_data, adc_valid,
    output rx_enable, receive_in_progress, aline_valid, aline_data,
           aline_last, receive_complete
  );

endinterface

// File: rtl/receive_fsm_rx_delay_line.sv
// One channel's delay line: circular buffer indexed by the acquisition sample
// index, with a registered tap of the sample `delay` positions behind.
module receive_fsm_rx_delay_line
  import receive_fsm_pkg::*;
(
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [COUNT_W-1:0]         idx,
  input  logic [DELAY_W-1:0]         delay,
  input  logic                       used,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [SAMPLE_W-1:0] tap_p0
);

  logic signed [SAMPLE_W-1:0] mem [DEPTH];
  logic [DELAY_W-1:0]         wr_addr;
  logic [DELAY_W-1:0]         rd_addr;

  // The low index bits address the ring; the read slot is always an older one.
  assign wr_addr = idx[DELAY_W-1:0];
  assign rd_addr = wr_addr - delay;

  // ---- stage p0: buffer write and gated tap read ----
  // Samples before index `delay` read as zero so stale A-line data never leaks.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= sample;
      if (!used || (idx < COUNT_W'(delay)))
        tap_p0 <= '0;
      else if (delay == '0)
        tap_p0 <= sample;
      else
        tap_p0 <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/receive_fsm.sv
// Receive sequencer: blanking, acquisition, delay-and-sum of NUM_CH channels
// into one A-line stream with fixed two-cycle latency, then drain and done.
module receive_fsm
  import receive_fsm_pkg::*;
(
  input logic          clk,
  input logic          rst,
  receive_fsm_if.slave bus
);

  function automatic logic signed [SUM_W-1:0] sext_sample(
    input logic signed [SAMPLE_W-1:0] x
  );
    return {{(SUM_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

  state_t                     state;
  state_t                     state_nxt;
  logic [COUNT_W-1:0]         blank_cnt;
  logic [COUNT_W-1:0]         idx;
  logic [COUNT_W-1:0]         n_lat;
  logic [NUM_CH-1:0]          used_lat;
  logic [NUM_CH*DELAY_W-1:0]  delays;
  logic                       drain_cnt;
  logic                       start_ok;
  logic                       fire;
  logic                       last_sample;
  logic                       vld_p0;
  logic                       last_p0;
  logic                       vld_p1;
  logic                       last_p1;
  logic signed [SAMPLE_W-1:0] tap_p0 [NUM_CH];
  logic signed [SUM_W-1:0]    sum_p0;
  logic signed [SUM_W-1:0]    data_p1;

  // abort wins over a simultaneous arm and masks a simultaneous sample.
  assign start_ok    = (state == ST_IDLE) && bus.start_receive && !bus.abort;
  assign fire        = (state == ST_ACQUIRE) && bus.adc_valid && !bus.abort;
  assign last_sample = (idx == (n_lat - COUNT_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_ok) state_nxt = ST_BLANK;
      ST_BLANK:   if (blank_cnt <= COUNT_W'(1))
                    state_nxt = (n_lat == '0) ? ST_DONE : ST_ACQUIRE;
      ST_ACQUIRE: if (fire && last_sample) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (bus.abort) state_nxt = ST_IDLE;
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    bus.rx_enable           = (state == ST_ACQUIRE);
    bus.receive_in_progress = (state == ST_BLANK) || (state == ST_ACQUIRE) ||
                              (state == ST_DRAIN);
    bus.receive_complete    = (state == ST_DONE);
  end

  // Per-A-line settings latched at arm time, blank/sample/drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= '0;
      idx       <= '0;
      n_lat     <= '0;
      used_lat  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_ok) begin
        blank_cnt <= bus.blank_cycles;
        n_lat     <= bus.num_samples;
        used_lat  <= bus.used_channels;
        idx       <= '0;
      end else if ((state == ST_BLANK) && (blank_cnt > COUNT_W'(1))) begin
        blank_cnt <= blank_cnt - COUNT_W'(1);
      end
      if (fire) idx <= idx + COUNT_W'(1);
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Delays change only between A-lines, so they stay fixed during acquisition.
  always_ff @(posedge clk) begin
    if (rst)
      delays <= '0;
    else if ((state == ST_IDLE) && bus.load_delays)
      delays <= bus.rx_delays;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    receive_fsm_rx_delay_line u_line (
      .clk    (clk),
      .wr_en  (fire),
      .idx    (idx),
      .delay  (delays[c*DELAY_W +: DELAY_W]),
      .used   (used_lat[c]),
      .sample ($signed(bus.adc_data[c*SAMPLE_W +: SAMPLE_W])),
      .tap_p0 (tap_p0[c])
    );
  end

  // ---- stage p0 -> p1: adder tree over the registered taps ----
  // Sum of all channel taps, sign-extended to the A-line width.
  always_comb begin
    sum_p0 = '0;
    for (int c = 0; c < NUM_CH; c++)
      sum_p0 = sum_p0 + sext_sample(tap_p0[c]);
  end

  // Valid/last travel with the data; abort flushes whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p0  <= fire;
      last_p0 <= fire && last_sample;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  // ---- stage p1: registered A-line sample ----
  // Output data register; cleared on reset so the port reads zero from power-up.
  always_ff @(posedge clk) begin
    if (rst)
      data_p1 <= '0;
    else if (vld_p0)
      data_p1 <= sum_p0;
  end

  assign bus.aline_valid = vld_p1;
  assign bus.aline_last  = last_p1;
  assign bus.aline_data  = data_p1;

endmodule

// File: tb/tb_receive_fsm.sv
// Directed bench for receive_fsm: vector table of A-line runs plus hand-written
// sequences for empty A-line, abort, delay-load timing and mid-run reset.
module tb_receive_fsm;
  import receive_fsm_pkg::*;

  typedef struct packed {
    logic [7:0]        used;
    logic [47:0]       delays;
    logic [15:0]       blank;
    logic [15:0]       n;
    logic              gaps;
    logic [4:0][95:0]  adc;
    logic [4:0][14:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   n_last = 0;
  int   n_rx = 0;
  int   done_cyc = 0;
  logic [14:0] q_data[$];
  int          q_cyc[$];
  logic        q_last[$];
  vec_t        tbl[7];

  receive_fsm_if bus();

  receive_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.aline_valid) begin
      q_data.push_back(bus.aline_data);
      q_cyc.push_back(cyc);
      q_last.push_back(bus.aline_last);
    end
    if (bus.aline_last)       n_last   <= n_last + 1;
    if (bus.receive_complete) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (bus.rx_enable)        n_rx     <= n_rx + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] rep(input int v);
    logic [95:0] w;
    for (int c = 0; c < 8; c++) w[c*12 +: 12] = 12'(v);
    return w;
  endfunction

  function automatic logic [95:0] set_ch(input logic [95:0] w, input int c, input int v);
    logic [95:0] r;
    r = w;
    r[c*12 +: 12] = 12'(v);
    return r;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_cyc.delete();
    q_last.delete();
  endtask

  // Arm, feed the vector's samples (with noise on adc_valid during BLANK), compare.
  task automatic run_vec(input int id, input vec_t v, input bit poke, input bit skip_load);
    int adc_cyc[$];
    int start_cyc;
    int t;
    int d0;
    int n;
    int blank_exp;
    n = int'(v.n);
    blank_exp = (v.blank == 16'd0) ? 1 : int'(v.blank);
    clear_q();
    d0 = n_done;
    if (!skip_load) begin
      bus.rx_delays   = v.delays;
      bus.load_delays = 1'b1;
      step();
      bus.load_delays = 1'b0;
    end
    bus.used_channels = v.used;
    bus.blank_cycles  = v.blank;
    bus.num_samples   = v.n;
    bus.start_receive = 1'b1;
    start_cyc = cyc;
    step();
    bus.start_receive = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data  = '1;
    t = 0;
    while (!bus.rx_enable && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk($sformatf("v%0d_rx_enable_timeout", id), 0, 1);
    chk($sformatf("v%0d_blank_len", id), cyc - (start_cyc + 1), blank_exp);
    for (int k = 0; k < n; k++) begin
      if (v.gaps && (k % 2 == 1)) begin
        bus.adc_valid = 1'b0;
        step();
      end
      bus.adc_valid = 1'b1;
      bus.adc_data  = v.adc[k];
      adc_cyc.push_back(cyc);
      if (poke && k == 1) begin
        bus.load_delays = 1'b1;
        bus.rx_delays   = {8{6'd5}};
      end
      step();
      bus.load_delays = 1'b0;
    end
    bus.adc_valid = 1'b0;
    t = 0;
    while (n_done == d0 && t < 50) begin
      step();
      t++;
    end
    step();
    step();
    chk($sformatf("v%0d_complete_count", id), n_done - d0, 1);
    chk($sformatf("v%0d_complete_lat", id), done_cyc, adc_cyc[n-1] + 3);
    chk($sformatf("v%0d_valid_count", id), q_data.size(), n);
    for (int k = 0; k < n && k < q_data.size(); k++) begin
      chk($sformatf("v%0d_data%0d", id, k), q_data[k], v.exp[k]);
      chk($sformatf("v%0d_latency%0d", id, k), q_cyc[k], adc_cyc[k] + 2);
      chk($sformatf("v%0d_last%0d", id, k), q_last[k], (k == n - 1));
    end
  endtask

  initial begin
    vec_t vnd;
    int   d0;
    int   l0;
    int   r0;
    int   t;
    int   abort_cyc;
    int   late;

    bus.start_receive = 1'b0;
    bus.abort         = 1'b0;
    bus.load_delays   = 1'b0;
    bus.rx_delays     = '0;
    bus.used_channels = '0;
    bus.blank_cycles  = '0;
    bus.num_samples   = '0;
    bus.adc_data      = '0;
    bus.adc_valid     = 1'b0;

    for (int i = 0; i < 7; i++) tbl[i] = '0;
    // 1: all delays 0, all channels, +1..+4 on every channel
    tbl[0].used = 8'hFF; tbl[0].blank = 16'd3; tbl[0].n = 16'd4;
    for (int k = 0; k < 4; k++) begin
      tbl[0].adc[k] = rep(k + 1);
      tbl[0].exp[k] = 15'(8 * (k + 1));
    end
    // 2: ch0 delayed by 2, others masked (fed with 99)
    tbl[1].used = 8'h01; tbl[1].delays = 48'd2; tbl[1].blank = 16'd2; tbl[1].n = 16'd5;
    for (int k = 0; k < 5; k++) tbl[1].adc[k] = set_ch(rep(99), 0, 10 + k);
    tbl[1].exp[0] = 15'd0;  tbl[1].exp[1] = 15'd0;  tbl[1].exp[2] = 15'd10;
    tbl[1].exp[3] = 15'd11; tbl[1].exp[4] = 15'd12;
    // 3: most negative input on all channels
    tbl[2].used = 8'hFF; tbl[2].blank = 16'd1; tbl[2].n = 16'd2;
    for (int k = 0; k < 2; k++) begin
      tbl[2].adc[k] = rep(-2048);
      tbl[2].exp[k] = 15'h4000;
    end
    // 3b: same input, no channel used
    tbl[3] = tbl[2];
    tbl[3].used = 8'h00;
    tbl[3].exp[0] = 15'd0; tbl[3].exp[1] = 15'd0;
    // lower four channels only, ch c = (k+1)*(c+1)
    tbl[4].used = 8'h0F; tbl[4].blank = 16'd0; tbl[4].n = 16'd3;
    for (int k = 0; k < 3; k++) begin
      tbl[4].adc[k] = '0;
      for (int c = 0; c < 8; c++) tbl[4].adc[k] = set_ch(tbl[4].adc[k], c, (k + 1) * (c + 1));
      tbl[4].exp[k] = 15'(10 * (k + 1));
    end
    // every channel delayed by one, near positive full scale
    tbl[5].used = 8'hFF; tbl[5].delays = {8{6'd1}}; tbl[5].blank = 16'd2; tbl[5].n = 16'd3;
    tbl[5].adc[0] = rep(2047); tbl[5].adc[1] = rep(100); tbl[5].adc[2] = rep(5);
    tbl[5].exp[0] = 15'd0; tbl[5].exp[1] = 15'd16376; tbl[5].exp[2] = 15'd800;
    // mixed delays 0/1/2 with gaps in adc_valid
    tbl[6].used = 8'h07; tbl[6].delays = 48'((2 << 12) | (1 << 6)); tbl[6].blank = 16'd1;
    tbl[6].n = 16'd4; tbl[6].gaps = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tbl[6].adc[k] = set_ch('0, 0, 1);
      tbl[6].adc[k] = set_ch(tbl[6].adc[k], 1, 100 * (k + 1));
      tbl[6].adc[k] = set_ch(tbl[6].adc[k], 2, 1000 + 100 * k);
      tbl[6].adc[k] = set_ch(tbl[6].adc[k], 3, 777);
    end
    tbl[6].exp[0] = 15'd1; tbl[6].exp[1] = 15'd101;
    tbl[6].exp[2] = 15'd1201; tbl[6].exp[3] = 15'd1401;

    repeat (3) step();
    chk("reset_rx_enable", bus.rx_enable, 0);
    chk("reset_in_progress", bus.receive_in_progress, 0);
    chk("reset_aline_valid", bus.aline_valid, 0);
    chk("reset_aline_data", bus.aline_data, 0);
    chk("reset_aline_last", bus.aline_last, 0);
    chk("reset_complete", bus.receive_complete, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i], 1'b0, 1'b0);

    // Empty A-line: straight from BLANK to DONE.
    clear_q();
    d0 = n_done; r0 = n_rx;
    bus.num_samples = 16'd0; bus.blank_cycles = 16'd0; bus.used_channels = 8'hFF;
    bus.start_receive = 1'b1;
    abort_cyc = cyc;
    step();
    bus.start_receive = 1'b0;
    t = 0;
    while (n_done == d0 && t < 20) begin
      step();
      t++;
    end
    chk("n0_complete_count", n_done - d0, 1);
    chk("n0_complete_lat", done_cyc - abort_cyc, 2);
    chk("n0_valid_count", q_data.size(), 0);
    chk("n0_rx_enable", n_rx - r0, 0);

    // Abort at sample 2 of 10.
    clear_q();
    d0 = n_done; l0 = n_last;
    bus.rx_delays = '0; bus.load_delays = 1'b1;
    step();
    bus.load_delays = 1'b0;
    bus.used_channels = 8'hFF; bus.blank_cycles = 16'd1; bus.num_samples = 16'd10;
    bus.start_receive = 1'b1;
    step();
    bus.start_receive = 1'b0;
    t = 0;
    while (!bus.rx_enable && t < 50) begin
      step();
      t++;
    end
    bus.adc_valid = 1'b1; bus.adc_data = rep(1);
    step();
    step();
    bus.abort = 1'b1;
    abort_cyc = cyc;
    step();
    bus.abort = 1'b0; bus.adc_valid = 1'b0;
    chk("abort_rx_enable", bus.rx_enable, 0);
    chk("abort_in_progress", bus.receive_in_progress, 0);
    repeat (10) step();
    chk("abort_complete", n_done - d0, 0);
    chk("abort_last", n_last - l0, 0);
    late = 0;
    foreach (q_cyc[i]) if (q_cyc[i] > abort_cyc) late++;
    chk("abort_late_valid", late, 0);

    // abort and start together in IDLE: stay idle.
    bus.start_receive = 1'b1; bus.abort = 1'b1;
    step();
    bus.start_receive = 1'b0; bus.abort = 1'b0;
    chk("abort_prio_in_progress", bus.receive_in_progress, 0);
    repeat (3) step();
    chk("abort_prio_complete", n_done - d0, 0);

    // Clean run after abort; gating hides buffer contents from the aborted line.
    run_vec(10, tbl[1], 1'b0, 1'b0);

    // load_delays during ACQUIRE is ignored, and stays ignored on the next line.
    run_vec(11, tbl[0], 1'b1, 1'b0);
    run_vec(12, tbl[0], 1'b0, 1'b1);
    run_vec(13, tbl[1], 1'b0, 1'b0);

    // Reset mid-acquisition clears the delays back to zero.
    bus.used_channels = 8'h01; bus.blank_cycles = 16'd1; bus.num_samples = 16'd5;
    bus.start_receive = 1'b1;
    step();
    bus.start_receive = 1'b0;
    t = 0;
    while (!bus.rx_enable && t < 50) begin
      step();
      t++;
    end
    bus.adc_valid = 1'b1; bus.adc_data = rep(3);
    step();
    bus.adc_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_mid_rx_enable", bus.rx_enable, 0);
    chk("rst_mid_in_progress", bus.receive_in_progress, 0);
    chk("rst_mid_aline_valid", bus.aline_valid, 0);
    step();
    vnd = tbl[1];
    for (int k = 0; k < 5; k++) vnd.exp[k] = 15'(10 + k);
    run_vec(14, vnd, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
